// File: rtl/player_buzz_writer_pkg.sv
// Shared definitions for the buzzer writer and the memory block it talks to.
// Holds the memory-map addresses, the flag value, the FSM state encoding,
// the common counter width and a helper that picks the winning player.
package player_buzz_writer_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

  localparam logic [15:0] PLAYER_ID_ADDR = 16'h0026;
  localparam logic [15:0] BUZZ_FLAG_ADDR = 16'h0025;
  localparam logic [15:0] BUZZ_FLAG_SET  = 16'h0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ID,
    ST_WR_FLAG,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_POLL_CHK,
    ST_LOCKOUT
  } buzz_state_t;

  // Lowest-index pulsing button wins; returns player number 1..4, 0 if none.
  function automatic logic [2:0] first_player(input logic [3:0] pulses);
    first_player = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pulses[i]) first_player = 3'(i + 1);
    end
  endfunction

endpackage

// File: rtl/player_buzz_writer_if.sv
// Memory-port bundle between the buzzer writer (master) and the arbitrated
// memory (slave).
//   req       : master requests the memory port
//   grant     : arbiter grants the port this cycle
//   en        : memory access strobe
//   memwrite  : write strobe
//   memread   : read strobe
//   adr       : memory address
//   writedata : data to write
//   memdata   : read data, valid the cycle after a read strobe
interface player_buzz_writer_if #(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 16
) ();

  logic                     req;
  logic                     grant;
  logic                     en;
  logic                     memwrite;
  logic                     memread;
  logic [RAM_ADDR_BITS-1:0] adr;
  logic [WIDTH-1:0]         writedata;
  logic [WIDTH-1:0]         memdata;

  modport master (
    output req, en, memwrite, memread, adr, writedata,
    input  grant, memdata
  );

  modport slave (
    input  req, en, memwrite, memread, adr, writedata,
    output grant, memdata
  );

endinterface

// File: rtl/player_buzz_writer_btn_conditioner.sv
// Conditions one raw player button: two-flop synchronizer, debouncer and
// rising-edge detector producing a single-cycle pulse.
//   clk, rst : system clock, async active-high reset
//   btn_raw  : raw asynchronous button level
//   pulse    : one-cycle pulse on an accepted press
module btn_conditioner
  import player_buzz_writer_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic             primed_q, primed_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample;
  logic             want_change;

  // Until primed, the debouncer waits for a fully debounced low level, so a
  // button held through reset cannot produce a press until released first.
  // Once primed, it counts consecutive samples differing from the accepted
  // level and adopts the new level when the count completes.
  always_comb begin
    sync_d      = {sync_q[0], btn_raw};
    sample      = sync_q[1];
    stable_d    = stable_q;
    primed_d    = primed_q;
    prev_d      = stable_q;
    cnt_d       = '0;
    want_change = primed_q ? (sample != stable_q) : !sample;
    if (want_change) begin
      if (cnt_q == DEBOUNCE_CYCLES - CNT_ONE) begin
        if (primed_q) stable_d = sample;
        else          primed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      primed_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      primed_q <= primed_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse = stable_q & ~prev_q;

endmodule

// File: rtl/player_buzz_writer.sv
// Quiz buzzer writer: conditions four player buttons, latches the first
// player to buzz in, writes the player id and a buzz flag to memory, polls
// the flag until the CPU clears it, then enforces a lockout period.
//   clk, rst : system clock, async active-high reset
//   btn      : raw player buttons, bit i = player i+1
//   arm      : buzz-ins accepted only while high
//   bus      : memory port (master side)
//   winner   : latched winning player 1..4, 0 = none
//   busy     : high whenever the FSM is not idle
module player_buzz_writer
  import player_buzz_writer_pkg::*;
#(
  parameter int          WIDTH           = 16,
  parameter int          RAM_ADDR_BITS   = 16,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [15:0] POLL_INTERVAL   = 16'd64,
  parameter logic [15:0] LOCKOUT_CYCLES  = 16'd5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                btn,
  input  logic                      arm,
  player_buzz_writer_if.master      bus,
  output logic [2:0]                winner,
  output logic                      busy
);

  buzz_state_t      state_q, state_d;
  logic [2:0]       winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pulse;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn[i]),
      .pulse   (pulse[i])
    );
  end

  // Strobes are the state decode gated by grant; address and data are held
  // for the whole request state so a withheld grant just stretches it.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    cnt_d         = cnt_q;
    bus.req       = 1'b0;
    bus.en        = 1'b0;
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.adr       = '0;
    bus.writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (arm && (|pulse)) begin
          winner_d = first_player(pulse);
          state_d  = ST_WR_ID;
        end
      end
      ST_WR_ID: begin
        bus.req       = 1'b1;
        bus.adr       = RAM_ADDR_BITS'(PLAYER_ID_ADDR);
        bus.writedata = WIDTH'(winner_q);
        if (bus.grant) begin
          bus.en       = 1'b1;
          bus.memwrite = 1'b1;
          state_d      = ST_WR_FLAG;
        end
      end
      ST_WR_FLAG: begin
        bus.req       = 1'b1;
        bus.adr       = RAM_ADDR_BITS'(BUZZ_FLAG_ADDR);
        bus.writedata = WIDTH'(BUZZ_FLAG_SET);
        if (bus.grant) begin
          bus.en       = 1'b1;
          bus.memwrite = 1'b1;
          state_d      = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (cnt_q == POLL_INTERVAL - CNT_ONE) state_d = ST_POLL_RD;
        else                                   cnt_d   = cnt_q + CNT_ONE;
      end
      ST_POLL_RD: begin
        bus.req = 1'b1;
        bus.adr = RAM_ADDR_BITS'(BUZZ_FLAG_ADDR);
        if (bus.grant) begin
          bus.en      = 1'b1;
          bus.memread = 1'b1;
          state_d     = ST_POLL_CHK;
        end
      end
      ST_POLL_CHK: begin
        if (bus.memdata[0]) begin
          state_d = ST_POLL_WAIT;
        end else begin
          state_d  = ST_LOCKOUT;
          winner_d = 3'd0;
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q == LOCKOUT_CYCLES - CNT_ONE) state_d = ST_IDLE;
        else                                    cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state starts its count from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign winner = winner_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_buzz_writer.sv
// Scoreboard bench for player_buzz_writer: the stimulus thread pushes the
// expected memory transactions, a negedge monitor pops and compares them
// whenever the DUT strobes the memory port.
module tb_player_buzz_writer;
  import player_buzz_writer_pkg::*;

  localparam logic [15:0] DB = 16'd16;
  localparam logic [15:0] PI = 16'd8;
  localparam logic [15:0] LK = 16'd40;

  typedef struct {
    logic        is_write;
    logic [15:0] adr;
    logic [15:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       arm;
  logic [2:0] winner;
  logic       busy;

  player_buzz_writer_if #(.WIDTH(16), .RAM_ADDR_BITS(16)) bus ();

  player_buzz_writer #(
    .WIDTH           (16),
    .RAM_ADDR_BITS   (16),
    .DEBOUNCE_CYCLES (DB),
    .POLL_INTERVAL   (PI),
    .LOCKOUT_CYCLES  (LK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .arm    (arm),
    .bus    (bus),
    .winner (winner),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  int   n_txn = 0;
  int   n_reads = 0;
  int   prev_read_cyc = -1;
  int   last_read_cyc = 0;
  int   id_write_cyc = 0;
  int   flag_write_cyc = 0;
  txn_t sb_q[$];
  logic flag_q[$];
  txn_t exp_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every memory strobe must match the next expected transaction;
  // reads also get the next flag value and their spacing is checked.
  always @(negedge clk) begin
    if (rst) bus.memdata = '0;
    if (bus.en) begin
      n_txn++;
      tests++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL txn_unexpected: actual we=%0b re=%0b adr=%h data=%h, required no transaction",
                 bus.memwrite, bus.memread, bus.adr, bus.writedata);
      end else begin
        exp_t = sb_q.pop_front();
        if (bus.memwrite !== exp_t.is_write || bus.memread !== !exp_t.is_write ||
            bus.adr !== exp_t.adr || bus.writedata !== exp_t.data || bus.grant !== 1'b1) begin
          errors++;
          $display("[TB] FAIL txn_check: actual we=%0b re=%0b adr=%h data=%h grant=%0b, required we=%0b re=%0b adr=%h data=%h grant=1",
                   bus.memwrite, bus.memread, bus.adr, bus.writedata, bus.grant,
                   exp_t.is_write, !exp_t.is_write, exp_t.adr, exp_t.data);
        end
      end
      if (bus.memread) begin
        n_reads++;
        if (prev_read_cyc >= 0) begin
          tests++;
          if (cyc - prev_read_cyc != int'(PI) + 2) begin
            errors++;
            $display("[TB] FAIL read_spacing: actual=%0d required=%0d", cyc - prev_read_cyc, int'(PI) + 2);
          end
        end
        prev_read_cyc = cyc;
        last_read_cyc = cyc;
        bus.memdata   = (flag_q.size() != 0) ? 16'(flag_q.pop_front()) : 16'h0000;
      end else begin
        prev_read_cyc = -1;
        if (bus.adr == PLAYER_ID_ADDR) id_write_cyc = cyc;
        else                           flag_write_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic a, input logic g);
    @(posedge clk);
    #1;
    btn       = b;
    arm       = a;
    bus.grant = g;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushTxn(input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.is_write = we;
    t.adr      = a;
    t.data     = d;
    sb_q.push_back(t);
  endtask

  // which: 0 = wait for busy == level, 1 = wait for winner != 0
  task automatic waitUntil(input string name, input int which, input logic level, input int budget);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      hit = (which == 0) ? (busy === level) : (winner !== 3'd0);
      n++;
    end
    tests++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL %s: actual=timeout after %0d cycles required=condition met", name, budget);
    end
  endtask

  task automatic playRound(input string name, input logic [3:0] b, input logic [2:0] exp_winner);
    pushTxn(1'b1, PLAYER_ID_ADDR, 16'(exp_winner));
    pushTxn(1'b1, BUZZ_FLAG_ADDR, 16'h0001);
    pushTxn(1'b0, BUZZ_FLAG_ADDR, 16'h0000);
    flag_q.push_back(1'b0);
    applyStimulus(b, 1'b1, 1'b1);
    waitUntil({name, "_latch"}, 1, 1'b1, int'(DB) + 10);
    checkOutput({name, "_winner"}, 32'(winner), 32'(exp_winner));
    applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil({name, "_done"}, 0, 1'b0, 2 * int'(PI) + int'(LK) + 20);
    checkOutput({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    idleCycles(int'(DB) + 6);
  endtask

  initial begin
    int n0;
    int rd0;
    int grant_cyc;
    logic [3:0] b;

    btn       = 4'b0000;
    arm       = 1'b1;
    bus.grant = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_strobes", {27'd0, bus.req, bus.en, bus.memwrite, bus.memread, busy}, 32'd0);
    checkOutput("reset_bus", {bus.adr, bus.writedata}, 32'd0);
    checkOutput("reset_winner", 32'(winner), 32'd0);
    rst = 1'b0;
    idleCycles(int'(DB) + 6);

    // Player 3 wins, flag read back 1, 1, 0.
    rd0 = n_reads;
    pushTxn(1'b1, PLAYER_ID_ADDR, 16'h0003);
    pushTxn(1'b1, BUZZ_FLAG_ADDR, 16'h0001);
    repeat (3) pushTxn(1'b0, BUZZ_FLAG_ADDR, 16'h0000);
    flag_q.push_back(1'b1);
    flag_q.push_back(1'b1);
    flag_q.push_back(1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    waitUntil("p3_latch", 1, 1'b1, int'(DB) + 10);
    checkOutput("p3_winner", 32'(winner), 32'd3);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil("p3_done", 0, 1'b0, 3 * (int'(PI) + 2) + int'(LK) + 20);
    checkOutput("p3_lockout_len", 32'(cyc - last_read_cyc), 32'(int'(LK) + 2));
    checkOutput("p3_flag_after_id", 32'(flag_write_cyc - id_write_cyc), 32'd1);
    checkOutput("p3_read_count", 32'(n_reads - rd0), 32'd3);
    checkOutput("p3_winner_cleared", 32'(winner), 32'd0);
    checkOutput("p3_sb_empty", 32'(sb_q.size()), 32'd0);
    idleCycles(int'(DB) + 6);

    // Players 2 and 4 press together: lowest index wins.
    playRound("p2p4", 4'b1010, 3'd2);

    // Grant withheld for 10 cycles in WR_ID.
    pushTxn(1'b1, PLAYER_ID_ADDR, 16'h0001);
    pushTxn(1'b1, BUZZ_FLAG_ADDR, 16'h0001);
    pushTxn(1'b0, BUZZ_FLAG_ADDR, 16'h0000);
    flag_q.push_back(1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    waitUntil("nogrant_busy", 0, 1'b1, int'(DB) + 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput("nogrant_hold", {12'd0, bus.req, bus.en, bus.memwrite, bus.memread, bus.adr},
                  {12'd0, 4'b1000, PLAYER_ID_ADDR});
      checkOutput("nogrant_data", 32'(bus.writedata), 32'd1);
      @(negedge clk);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    grant_cyc = cyc;
    waitUntil("nogrant_done", 0, 1'b0, 2 * int'(PI) + int'(LK) + 20);
    checkOutput("nogrant_first_grant_write", 32'(id_write_cyc), 32'(grant_cyc));
    checkOutput("nogrant_sb_empty", 32'(sb_q.size()), 32'd0);
    idleCycles(int'(DB) + 6);

    // Bouncing button never settles long enough.
    n0 = n_txn;
    b  = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(b, 1'b1, 1'b1);
      idleCycles(9);
      b = ~b & 4'b0001;
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    idleCycles(int'(DB) + 6);
    checkOutput("bounce_busy", 32'(busy), 32'd0);
    checkOutput("bounce_no_txn", 32'(n_txn - n0), 32'd0);

    // Press while disarmed is discarded, and arming later does not revive it.
    applyStimulus(4'b0010, 1'b0, 1'b1);
    idleCycles(int'(DB) + 10);
    checkOutput("disarmed_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    idleCycles(int'(DB) + 10);
    checkOutput("rearm_busy", 32'(busy), 32'd0);
    checkOutput("disarmed_no_txn", 32'(n_txn - n0), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    idleCycles(int'(DB) + 6);

    // Reset in WR_FLAG with player 4's button held through release.
    pushTxn(1'b1, PLAYER_ID_ADDR, 16'h0004);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    waitUntil("rst_busy", 0, 1'b1, int'(DB) + 10);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("rst_in_wr_flag", {bus.req, 15'd0, bus.adr}, {1'b1, 15'd0, BUZZ_FLAG_ADDR});
    n0  = n_txn;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_strobes", {27'd0, bus.req, bus.en, bus.memwrite, bus.memread, busy}, 32'd0);
    checkOutput("rst_bus", {bus.adr, bus.writedata}, 32'd0);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.grant = 1'b1;
    idleCycles(3 * int'(DB));
    checkOutput("held_no_txn", 32'(n_txn - n0), 32'd0);
    checkOutput("held_busy", 32'(busy), 32'd0);
    checkOutput("held_sb_empty", 32'(sb_q.size()), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    idleCycles(int'(DB) + 6);
    playRound("repress", 4'b1000, 3'd4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/player_buzz_writer.md
PLAYER_BUZZ_WRITER -- requirements
Module: player_buzz_writer

Interface
REQ-001 Parameter WIDTH, 16, memory data width.
REQ-002 Parameter RAM_ADDR_BITS, 16, memory address width.
REQ-003 Parameter DEBOUNCE_CYCLES, 16'd1000, stable-input cycles needed before a button level is accepted.
REQ-004 Parameter POLL_INTERVAL, 16'd64, idle cycles between flag polls.
REQ-005 Parameter LOCKOUT_CYCLES, 16'd5000, post-clear dead time.
REQ-006 Port clk  input  1  system clock; all state updates on rising edge.
REQ-007 Port rst  input  1  asynchronous, active-high reset.
REQ-008 Port btn  input  4  raw asynchronous player buttons, bit i = player i+1, active-high.
REQ-009 Port arm  input  1  when low, new buzz-ins are ignored.
REQ-010 Port grant  input  1  memory-port grant from the bus arbiter.
REQ-011 Port req  output  1  memory-port request.
REQ-012 Port en, memwrite, memread  output  1 each  memory strobes.
REQ-013 Port adr  output  RAM_ADDR_BITS  memory address.
REQ-014 Port writedata  output  WIDTH  memory write data.
REQ-015 Port memdata  input  WIDTH  memory read data, valid the cycle after a read strobe.
REQ-016 Port winner  output  3  latched winning player 1..4, 0 = none.
REQ-017 Port busy  output  1  high in every state except IDLE.

Function
REQ-018 Each btn bit SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive equal samples, then a rising-edge detector producing a 1-cycle pulse.
REQ-019 FSM states SHALL be IDLE, WR_ID, WR_FLAG, POLL_WAIT, POLL_RD, POLL_CHK, LOCKOUT.
REQ-020 IDLE: if arm=1 and any pulse, winner SHALL latch the lowest-index pulsing player number (1..4) and go to WR_ID; otherwise stay.
REQ-021 Pulses outside IDLE or with arm=0 SHALL be discarded, not queued.
REQ-022 WR_ID: req=1; on a cycle with grant=1, en=1, memwrite=1, adr=16'h0026, writedata=zero-extended winner; advance to WR_FLAG at that edge.
REQ-023 WR_FLAG: req=1; on grant=1, en=1, memwrite=1, adr=16'h0025, writedata=16'h0001; advance to POLL_WAIT, clearing poll counter.
REQ-024 POLL_WAIT: count to POLL_INTERVAL-1, then POLL_RD.
REQ-025 POLL_RD: req=1; on grant=1, en=1, memread=1, adr=16'h0025; advance to POLL_CHK.
REQ-026 POLL_CHK: sample memdata[0]; 1 -> POLL_WAIT; 0 (CPU cleared flag) -> LOCKOUT with winner cleared to 0.
REQ-027 LOCKOUT: count to LOCKOUT_CYCLES-1, then IDLE.
REQ-028 en, memwrite, memread SHALL be combinational AND of state decode and grant; never asserted with grant=0; memwrite and memread never both high.
REQ-029 grant=0 in a request state SHALL hold the state, req, adr and writedata stable indefinitely.
REQ-030 Outside request states req, en, memwrite, memread SHALL be 0 and adr, writedata SHALL be 0.
REQ-031 Counters SHALL be 16-bit, saturate-free, reset to 0 on every state entry.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, winner=0, busy=0, req/en/memwrite/memread=0, adr=0, writedata=0, all counters, synchronizer, debouncer and edge-detector flops to 0.
REQ-033 rst asserted mid-transaction SHALL abandon it; no partial write is reissued after release.
REQ-034 A button held through reset release SHALL NOT produce a pulse until released and re-pressed.

Structure
REQ-035 Memory-map constants (PLAYER_ID_ADDR=16'h0026, BUZZ_FLAG_ADDR=16'h0025) and state encoding SHALL live in a shared package/include used by the memory block and this block.
REQ-036 One sub-module, btn_conditioner (sync + debounce + edge, one instance per button), SHALL be used.

Verification
REQ-037 arm=1, grant=1, btn=4'b0100 held > DEBOUNCE_CYCLES -> write 16'h0003 to 16'h0026, then 16'h0001 to 16'h0025 on the next cycle; winner=3.
REQ-038 btn=4'b1010 rising same cycle -> winner=2, writedata=16'h0002.
REQ-039 grant=0 for 10 cycles in WR_ID -> req=1, en=0, adr/writedata stable; write occurs on first grant=1 cycle.
REQ-040 Flag memory returns 1 twice then 0 -> exactly three reads spaced POLL_INTERVAL+2 cycles, then LOCKOUT, winner=0, busy falls after LOCKOUT_CYCLES.
REQ-041 btn bounce (toggles every 10 cycles for 200 cycles) with DEBOUNCE_CYCLES=1000 -> no transaction.
REQ-042 rst pulsed in WR_FLAG -> outputs 0 same cycle; after release no write observed until a new press.
